// File: rtl/mvau_inp_buf_ctrl_if.sv
// Handshake/buffer-control bundle between the MVAU input-buffer controller,
// its upstream activation source, the downstream PE stage and mvau_inp_buffer.
// slave  : the controller side (mvau_inp_buf_ctrl).
// master : the surrounding stream environment.
interface mvau_inp_buf_ctrl_if #(
  parameter int unsigned BUF_ADDR = 4
);
  logic                in_v;
  logic                in_rdy;
  logic                out_rdy;
  logic                out_v;
  logic                wr_en;
  logic                rd_en;
  logic [BUF_ADDR-1:0] addr;
  logic                sf_last;
  logic                nf_last;

  modport slave (
    input  in_v, out_rdy,
    output in_rdy, out_v, wr_en, rd_en, addr, sf_last, nf_last
  );

  modport master (
    output in_v, out_rdy,
    input  in_rdy, out_v, wr_en, rd_en, addr, sf_last, nf_last
  );
endinterface

// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input-buffer controller. The first pass over an input vector writes each
// accepted word into mvau_inp_buffer while forwarding it downstream; the
// following NF-1 passes replay the stored vector from the buffer. Outputs are
// combinational from state/counters/handshake, gated off until one clock after
// reset release.
// Optional: MVAU_INP_BUF_CTRL_PERF_EN adds a saturating vec_cnt output that
// counts completed vectors (end of pass NF-1).
module mvau_inp_buf_ctrl #(
  parameter int unsigned SF       = 16,
  parameter int unsigned NF       = 16,
  parameter int unsigned BUF_ADDR = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef MVAU_INP_BUF_CTRL_PERF_EN
  output logic [31:0]        vec_cnt,
`endif
  mvau_inp_buf_ctrl_if.slave bus
);

  localparam int unsigned SF_W = (SF > 1) ? $clog2(SF) : 1;
  localparam int unsigned NF_W = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [SF_W-1:0] SF_MAX = SF_W'(SF - 1);
  localparam logic [NF_W-1:0] NF_MAX = NF_W'(NF - 1);

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_READ  = 1'b1
  } state_t;

  state_t              r_st, w_st_nxt;
  logic [SF_W-1:0]     r_sf, w_sf_nxt;
  logic [NF_W-1:0]     r_nf, w_nf_nxt;
  logic                r_act;

  logic                w_sf_end, w_nf_end, w_adv;
  logic                w_in_rdy, w_out_v, w_wr_en, w_rd_en;
  logic                w_sf_last, w_nf_last;
  logic [BUF_ADDR-1:0] w_addr;

  assign w_sf_end = (r_sf == SF_MAX);
  assign w_nf_end = (r_nf == NF_MAX);

  // State/counter registers; act enables outputs one clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= ST_WRITE;
      r_sf  <= '0;
      r_nf  <= '0;
      r_act <= 1'b0;
    end else begin
      r_st  <= w_st_nxt;
      r_sf  <= w_sf_nxt;
      r_nf  <= w_nf_nxt;
      r_act <= 1'b1;
    end
  end

  // Output decode and pass/column sequencing.
  always_comb begin
    w_st_nxt  = r_st;
    w_sf_nxt  = r_sf;
    w_nf_nxt  = r_nf;
    w_in_rdy  = 1'b0;
    w_out_v   = 1'b0;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_adv     = 1'b0;
    w_addr    = '0;
    w_sf_last = 1'b0;
    w_nf_last = 1'b0;

    if (r_act) begin
      w_addr = BUF_ADDR'(r_sf);
      if (r_st == ST_WRITE) begin
        w_in_rdy = bus.out_rdy;
        w_out_v  = bus.in_v;
        w_wr_en  = bus.in_v & bus.out_rdy;
        w_adv    = bus.in_v & bus.out_rdy;
      end else begin
        w_rd_en  = 1'b1;
        w_out_v  = 1'b1;
        w_adv    = bus.out_rdy;
      end
      w_sf_last = w_out_v & w_sf_end;
      w_nf_last = w_out_v & w_nf_end;
    end

    if (w_adv) begin
      w_sf_nxt = w_sf_end ? '0 : r_sf + SF_W'(1);
      if (w_sf_end) begin
        if (r_st == ST_WRITE) begin
          // With a single pass the block stays in WRITE and simply streams through.
          if (NF > 1) begin
            w_st_nxt = ST_READ;
            w_nf_nxt = NF_W'(1);
          end
        end else if (w_nf_end) begin
          w_st_nxt = ST_WRITE;
          w_nf_nxt = '0;
        end else begin
          w_nf_nxt = r_nf + NF_W'(1);
        end
      end
    end
  end

  assign bus.in_rdy  = w_in_rdy;
  assign bus.out_v   = w_out_v;
  assign bus.wr_en   = w_wr_en;
  assign bus.rd_en   = w_rd_en;
  assign bus.addr    = w_addr;
  assign bus.sf_last = w_sf_last;
  assign bus.nf_last = w_nf_last;

`ifdef MVAU_INP_BUF_CTRL_PERF_EN
  logic        w_vec_done;
  logic [31:0] r_vec_cnt;

  assign w_vec_done = w_adv & w_sf_end &
                      ((r_st == ST_READ) ? w_nf_end : (NF == 1));

  // Completed-vector counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt <= '0;
    end else if (w_vec_done && (r_vec_cnt != '1)) begin
      r_vec_cnt <= r_vec_cnt + 32'd1;
    end
  end

  assign vec_cnt = r_vec_cnt;
`endif

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Directed bench for mvau_inp_buf_ctrl: SF=4/NF=3 and SF=4/NF=1 instances run
// side by side (plus SF=2/NF=2 with the vector counter when enabled).
// Observed outputs are packed as {in_rdy,wr_en,rd_en,out_v,addr[1:0],sf_last,nf_last}.
module tb_mvau_inp_buf_ctrl;
  logic clk;
  logic rst_n;
  int unsigned n_pass;
  int unsigned n_tot;

  mvau_inp_buf_ctrl_if #(.BUF_ADDR(2)) ia ();
  mvau_inp_buf_ctrl_if #(.BUF_ADDR(2)) ib ();

  mvau_inp_buf_ctrl #(.SF(4), .NF(3), .BUF_ADDR(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  mvau_inp_buf_ctrl #(.SF(4), .NF(1), .BUF_ADDR(2)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

`ifdef MVAU_INP_BUF_CTRL_PERF_EN
  mvau_inp_buf_ctrl_if #(.BUF_ADDR(1)) ic ();
  logic [31:0] vec_cnt;
  mvau_inp_buf_ctrl #(.SF(2), .NF(2), .BUF_ADDR(1)) u_c (
    .clk(clk), .rst_n(rst_n), .vec_cnt(vec_cnt), .bus(ic)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pk_a();
    return {ia.in_rdy, ia.wr_en, ia.rd_en, ia.out_v, ia.addr, ia.sf_last, ia.nf_last};
  endfunction

  function automatic logic [7:0] pk_b();
    return {ib.in_rdy, ib.wr_en, ib.rd_en, ib.out_v, ib.addr, ib.sf_last, ib.nf_last};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Free-running SF=4,NF=3 sequence and the matching SF=4,NF=1 sequence.
  logic [7:0] exp1a [13] = '{8'hD0, 8'hD4, 8'hD8, 8'hDE,
                             8'h30, 8'h34, 8'h38, 8'h3E,
                             8'h31, 8'h35, 8'h39, 8'h3F, 8'hD0};
  logic [7:0] exp1b [4]  = '{8'hD1, 8'hD5, 8'hD9, 8'hDF};
  // Sparse in_v on NF=3 and out_rdy stalls on NF=1 after mid-run reset.
  logic       pat_v   [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] exp3a   [8] = '{8'hD0, 8'h84, 8'h84, 8'hD4, 8'hD8, 8'h8C, 8'hDE, 8'h30};
  logic       pat_rdy [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] exp3b   [8] = '{8'hD1, 8'h15, 8'hD5, 8'hD9, 8'hDF, 8'h11, 8'hD1, 8'hD5};

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst_n  = 1'b0;
    ia.in_v = 1'b1; ia.out_rdy = 1'b1;
    ib.in_v = 1'b1; ib.out_rdy = 1'b1;
`ifdef MVAU_INP_BUF_CTRL_PERF_EN
    ic.in_v = 1'b1; ic.out_rdy = 1'b1;
`endif
    cyc();
    cyc();
    #2;
    chk("rst_a", {24'd0, pk_a()}, 32'h00);
    chk("rst_b", {24'd0, pk_b()}, 32'h00);

    // Release between edges: outputs stay gated until the next edge.
    rst_n = 1'b1;
    #2;
    chk("act0_a", {24'd0, pk_a()}, 32'h00);
    chk("act0_b", {24'd0, pk_b()}, 32'h00);

    // Continuous streaming: write pass then two replay passes.
    for (int i = 0; i < 13; i++) begin
      cyc();
      #2;
      chk($sformatf("run_a%0d", i), {24'd0, pk_a()}, {24'd0, exp1a[i]});
      chk($sformatf("run_b%0d", i), {24'd0, pk_b()}, {24'd0, exp1b[i % 4]});
    end

    // Cycles 13..17 bring u_a to READ pass 1 at addr 2 on cycle 18.
    for (int i = 13; i < 18; i++) cyc();
    cyc();
    ia.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("stall_a%0d", i), {24'd0, pk_a()}, 32'h38);
      if (i < 2) cyc();
    end

    // Asynchronous reset in the middle of a replay pass.
    rst_n = 1'b0;
    #1;
    chk("midrst_a", {24'd0, pk_a()}, 32'h00);
    chk("midrst_b", {24'd0, pk_b()}, 32'h00);
    ia.out_rdy = 1'b1;
    cyc();
    rst_n = 1'b1;
    ia.in_v = 1'b0;
    #2;
    chk("midact_a", {24'd0, pk_a()}, 32'h00);

    for (int i = 0; i < 8; i++) begin
      cyc();
      ia.in_v    = pat_v[i];
      ib.out_rdy = pat_rdy[i];
      #2;
      chk($sformatf("pat_a%0d", i), {24'd0, pk_a()}, {24'd0, exp3a[i]});
      chk($sformatf("pat_b%0d", i), {24'd0, pk_b()}, {24'd0, exp3b[i]});
`ifdef MVAU_INP_BUF_CTRL_PERF_EN
      chk($sformatf("vcnt%0d", i), vec_cnt, (i >= 4) ? 32'd1 : 32'd0);
`endif
    end
`ifdef MVAU_INP_BUF_CTRL_PERF_EN
    cyc();
    #2;
    chk("vcnt8", vec_cnt, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
